// File: rtl/imem_fetch.sv
// -----------------------------------------------------------------------------
// imem_fetch
//
// Instruction fetch unit between the PC register and instruction memory.
// Fetch addresses are accepted from the PC side one at a time. Each aligned
// address becomes a single outstanding req/ack transaction to instruction
// memory. Fetched words, tagged with their PC, are queued in a small FIFO that
// the decoder drains with valid/ready. A misaligned address does not go to
// memory. It is queued directly as a fault entry. A flush empties the FIFO and
// throws away the response of any request that is still outstanding.
//
// Parameters
//   DEPTH     instruction buffer entries (>= 1, power of two)
//   RESET_PC  value of mem_addr after reset
//
// Ports
//   clk            clock, all state updates on the rising edge
//   rst            asynchronous active-high reset
//   pc_in          fetch address
//   pc_valid       pc_in valid
//   pc_ready       address accepted when pc_valid && pc_ready at a rising edge
//   flush          discard buffered and in-flight fetches
//   mem_req        memory request, held until mem_ack
//   mem_addr       request address, stable while mem_req=1
//   mem_ack        response valid, only looked at while mem_req=1
//   mem_rdata      instruction word, valid with mem_ack
//   instr_out      head-of-buffer instruction word
//   instr_pc       PC of the head entry
//   instr_misalign head entry is a misalignment fault
//   instr_valid    buffer non-empty
//   instr_ready    decoder pops the head when instr_valid && instr_ready
// -----------------------------------------------------------------------------
module imem_fetch #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] RESET_PC = 32'h00400000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        instr_misalign,
  output logic        instr_valid,
  input  logic        instr_ready
);

  // DEPTH=1 would give a zero-width pointer, so keep at least one bit.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic               mem_req_q, mem_req_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;

  logic [31:0]        buf_instr_q [DEPTH];
  logic [31:0]        buf_pc_q    [DEPTH];
  logic               buf_mis_q   [DEPTH];

  logic               accept;
  logic               push_req;
  logic               do_push;
  logic               do_pop;
  logic [31:0]        push_instr;
  logic [31:0]        push_pc;
  logic               push_mis;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // pc_ready is never raised by a same-cycle pop. Because IDLE is the only
  // state that accepts, a slot that was free at accept time stays reserved
  // for the response, even though count is unchanged while in WAIT.
  assign pc_ready    = (state_q == IDLE) && (count_q < CNT_W'(DEPTH)) && !flush;
  assign accept      = pc_valid && pc_ready;
  assign instr_valid = (count_q != '0);

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;

  assign instr_out      = buf_instr_q[rd_ptr_q];
  assign instr_pc       = buf_pc_q[rd_ptr_q];
  assign instr_misalign = buf_mis_q[rd_ptr_q];

  // Fetch FSM: next state, request handshake and push source selection.
  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    push_req   = 1'b0;
    push_instr = '0;
    push_pc    = '0;
    push_mis   = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (pc_in[1:0] == 2'b00) begin
            mem_addr_d = pc_in;
            mem_req_d  = 1'b1;
            state_d    = WAIT;
          end else begin
            push_req = 1'b1;
            push_pc  = pc_in;
            push_mis = 1'b1;
          end
        end
      end
      WAIT: begin
        if (mem_ack) begin
          mem_req_d  = 1'b0;
          state_d    = IDLE;
          push_req   = !flush;
          push_instr = mem_rdata;
          push_pc    = mem_addr_q;
        end else if (flush) begin
          // The request cannot be withdrawn. Keep it up and discard its response.
          state_d = DROP;
        end
      end
      DROP: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: begin
        mem_req_d = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  // flush overrides both push and pop on the same edge.
  assign do_push = push_req && !flush;
  assign do_pop  = instr_valid && instr_ready && !flush;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // One register set per buffer entry. Entries keep their contents across a
  // flush. Only the pointers and the count are cleared.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          buf_instr_q[gi] <= '0;
          buf_pc_q[gi]    <= '0;
          buf_mis_q[gi]   <= 1'b0;
        end else if (do_push && (wr_ptr_q == PTR_W'(gi))) begin
          buf_instr_q[gi] <= push_instr;
          buf_pc_q[gi]    <= push_pc;
          buf_mis_q[gi]   <= push_mis;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_imem_fetch.sv
module tb_imem_fetch;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h00400000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_misalign;
  logic        instr_valid;
  logic        instr_ready;

  imem_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst            (rst),
    .pc_in          (pc_in),
    .pc_valid       (pc_valid),
    .pc_ready       (pc_ready),
    .flush          (flush),
    .mem_req        (mem_req),
    .mem_addr       (mem_addr),
    .mem_ack        (mem_ack),
    .mem_rdata      (mem_rdata),
    .instr_out      (instr_out),
    .instr_pc       (instr_pc),
    .instr_misalign (instr_misalign),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: the queue of entries the decoder should see, plus the
  // single outstanding memory request (if any) and whether its response is to
  // be thrown away.
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        mis;
  } ent_t;

  ent_t        exp_q[$];
  bit          outst;
  bit          disc;
  logic [31:0] oaddr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    outst = 1'b0;
    disc  = 1'b0;
    oaddr = RESET_PC;
  endtask

  // One clock cycle: drive inputs, compare every visible output against the
  // model, advance the model across the coming rising edge, and then wait for
  // the next falling edge.
  task automatic step(input bit pv, input logic [31:0] pc, input bit fl,
                      input bit ack, input logic [31:0] rdata, input bit rdy);
    bit   exp_ready;
    bit   pop;
    ent_t e;
    pc_valid    = pv;
    pc_in       = pc;
    flush       = fl;
    mem_ack     = ack;
    mem_rdata   = rdata;
    instr_ready = rdy;
    #1;
    exp_ready = !outst && (exp_q.size() < DEPTH) && !fl;
    chk("pc_ready", 32'(pc_ready), 32'(exp_ready));
    chk("mem_req", 32'(mem_req), 32'(outst));
    if (outst) chk("mem_addr", mem_addr, oaddr);
    chk("instr_valid", 32'(instr_valid), 32'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      chk("instr_out", instr_out, exp_q[0].instr);
      chk("instr_pc", instr_pc, exp_q[0].pc);
      chk("instr_misalign", 32'(instr_misalign), 32'(exp_q[0].mis));
    end
    $display("step pv=%0d pc=%h fl=%0d ack=%0d rd=%h rdy=%0d | q=%0d outst=%0d disc=%0d",
             pv, pc, fl, ack, rdata, rdy, exp_q.size(), outst, disc);

    pop = (exp_q.size() > 0) && rdy && !fl;
    if (pop) void'(exp_q.pop_front());
    if (outst && ack) begin
      if (!disc && !fl) begin
        e.instr = rdata; e.pc = oaddr; e.mis = 1'b0;
        exp_q.push_back(e);
      end
      outst = 1'b0;
      disc  = 1'b0;
    end else if (outst && fl) begin
      disc = 1'b1;
    end
    if (pv && exp_ready) begin
      if (pc[1:0] == 2'b00) begin
        outst = 1'b1;
        disc  = 1'b0;
        oaddr = pc;
      end else begin
        e.instr = '0; e.pc = pc; e.mis = 1'b1;
        exp_q.push_back(e);
      end
    end
    if (fl) exp_q.delete();
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rpc;
    rst = 1'b1; pc_in = '0; pc_valid = 1'b0; flush = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0; instr_ready = 1'b0;
    model_reset();

    // Reset state
    #12;
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_addr", mem_addr, RESET_PC);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr_out", instr_out, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_instr_mis", 32'(instr_misalign), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_pc_ready", 32'(pc_ready), 32'd1);

    // Basic fetch
    step(1, 32'h00400000, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h2008000A, 0);
    chk("basic_valid", 32'(instr_valid), 32'd1);
    chk("basic_out", instr_out, 32'h2008000A);
    chk("basic_pc", instr_pc, 32'h00400000);
    step(0, 0, 0, 0, 0, 1);
    chk("basic_popped", 32'(instr_valid), 32'd0);

    // Backpressure: only DEPTH fetches fit, third waits for a pop
    step(1, 32'h00400000, 0, 0, 0, 0);
    step(1, 32'h00400004, 0, 1, 32'hA0A0A0A0, 0);
    step(1, 32'h00400004, 0, 0, 0, 0);
    step(1, 32'h00400008, 0, 1, 32'hA1A1A1A1, 0);
    chk("bp_full_ready", 32'(pc_ready), 32'd0);
    step(1, 32'h00400008, 0, 0, 0, 0);
    step(1, 32'h00400008, 0, 0, 0, 1);
    step(1, 32'h00400008, 0, 0, 0, 0);
    chk("bp_third_req", 32'(mem_req), 32'd1);
    chk("bp_third_addr", mem_addr, 32'h00400008);
    step(0, 0, 0, 1, 32'hA2A2A2A2, 0);
    chk("bp_head_pc", instr_pc, 32'h00400004);
    step(0, 0, 0, 0, 0, 1);
    chk("bp_next_out", instr_out, 32'hA2A2A2A2);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);

    // Misaligned fetch
    step(1, 32'h00400002, 0, 0, 0, 0);
    chk("mis_req", 32'(mem_req), 32'd0);
    chk("mis_valid", 32'(instr_valid), 32'd1);
    chk("mis_flag", 32'(instr_misalign), 32'd1);
    chk("mis_out", instr_out, 32'd0);
    chk("mis_pc", instr_pc, 32'h00400002);
    step(0, 0, 0, 0, 0, 1);

    // Flush while a request is in flight
    step(1, 32'h00400010, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("drop_req_held", 32'(mem_req), 32'd1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'hDEADBEEF, 1);
    chk("drop_valid", 32'(instr_valid), 32'd0);
    chk("drop_req_low", 32'(mem_req), 32'd0);
    step(1, 32'h00400020, 0, 0, 0, 0);
    step(0, 0, 0, 1, 32'h12345678, 0);
    chk("after_drop_out", instr_out, 32'h12345678);
    chk("after_drop_pc", instr_pc, 32'h00400020);
    step(0, 0, 0, 0, 0, 1);

    // Flush with simultaneous ack and pop while the last slot is reserved
    step(1, 32'h00400001, 0, 0, 0, 0);
    step(1, 32'h00400030, 0, 0, 0, 0);
    step(0, 0, 1, 1, 32'hCAFEF00D, 1);
    chk("fl_ack_valid", 32'(instr_valid), 32'd0);
    chk("fl_ack_req", 32'(mem_req), 32'd0);
    step(0, 0, 0, 0, 0, 0);

    // Reset in the middle of a WAIT
    step(1, 32'h00400040, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_req", 32'(mem_req), 32'd0);
    chk("midrst_valid", 32'(instr_valid), 32'd0);
    chk("midrst_addr", mem_addr, RESET_PC);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_ready", 32'(pc_ready), 32'd1);

    // Randomized traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rpc = $urandom;
      if ($urandom_range(0, 3) != 0) rpc[1:0] = 2'b00;
      step($urandom_range(0, 1) == 1, rpc, $urandom_range(0, 11) == 0,
           $urandom_range(0, 4) < 2, $urandom, $urandom_range(0, 2) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/imem_fetch.md
# imem_fetch

Instruction fetch unit between the PC register and instruction memory. Accepts a fetch address from the PC side, issues one request at a time to instruction memory over a req/ack handshake, and delivers fetched words (tagged with their PC) to the decoder through a small FIFO with valid/ready. Supports pipeline flush, including discarding responses still in flight, and flags misaligned fetch addresses without touching memory.

## Interface
- DEPTH, 2, instruction buffer entries (≥1, power of two)
- RESET_PC, 32'h00400000, reset value of mem_addr

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- pc_in  in  32  fetch address
- pc_valid  in  1  pc_in valid
- pc_ready  out  1  fetch address accepted when pc_valid && pc_ready at rising edge
- flush  in  1  discard buffered and in-flight fetches
- mem_req  out  1  memory request
- mem_addr  out  32  request address, stable while mem_req=1
- mem_ack  in  1  response valid; sampled only while mem_req=1
- mem_rdata  in  32  instruction word, valid with mem_ack
- instr_out  out  32  head-of-buffer instruction
- instr_pc  out  32  PC of head entry
- instr_misalign  out  1  head entry is a misalignment fault
- instr_valid  out  1  buffer non-empty
- instr_ready  in  1  decoder pops head when instr_valid && instr_ready

## Operation
- FSM states IDLE, WAIT, DROP; buffer count 0..DEPTH.
- pc_ready = (state==IDLE) && (count<DEPTH) && !flush; combinational, no pop-through.
- IDLE, accept with pc_in[1:0]==0: mem_addr<=pc_in, mem_req<=1, →WAIT. Slot is implicitly reserved (only WAIT can push).
- IDLE, accept with pc_in[1:0]!=0: push {instr=0, pc=pc_in, misalign=1}; no request; stay IDLE.
- WAIT, mem_ack && !flush: push {mem_rdata, mem_addr, misalign=0}; mem_req<=0; →IDLE.
- WAIT, flush && mem_ack: discard data; mem_req<=0; →IDLE.
- WAIT, flush && !mem_ack: →DROP; mem_req stays 1 (request may not be withdrawn), mem_addr unchanged.
- DROP: on mem_ack discard data, mem_req<=0, →IDLE. flush in DROP has no further effect.
- mem_ack while mem_req=0 ignored.
- Pop: instr_valid && instr_ready advances head; pop and push in the same cycle keep count unchanged.
- flush: count<=0, pointers reset, same-edge push and pop suppressed; flush wins over everything except rst.
- instr_out/instr_pc/instr_misalign driven from head entry; contents undefined-but-stable (zero after reset) when instr_valid=0.

## Timing
- Reset (async, immediate): state IDLE, count 0, mem_req 0, mem_addr RESET_PC, instr_valid 0, instr_out 0, instr_pc 0, instr_misalign 0, all buffer entries 0; pc_ready 1 once rst deasserts.
- Reset mid-WAIT/DROP: request abandoned, mem_req low immediately; memory side must tolerate.
- Accept at edge N → mem_req=1 after N. mem_ack sampled at edge M>N → instr_valid=1 after M. Minimum fetch latency 2 edges; peak throughput one fetch per 2 cycles.
- Misaligned accept at edge N → instr_valid=1 after N (1-cycle latency).
- Full (count==DEPTH): pc_ready=0 until a pop edge; pc_ready rises the cycle after that edge.
- Empty: instr_valid=0; instr_ready ignored.

## Test plan
- Reset: assert rst mid-cycle with state WAIT → mem_req, instr_valid low immediately; mem_addr=32'h00400000; pc_ready=1 after release.
- Basic fetch: pc_in=32'h00400000 accepted, mem_ack one cycle later with mem_rdata=32'h2008000A → instr_valid=1, instr_out=32'h2008000A, instr_pc=32'h00400000; pop with instr_ready=1 → instr_valid=0.
- Backpressure: instr_ready=0, fetch 0x00400000/04/08 → only first DEPTH=2 accepted, pc_ready=0 with count 2; one pop → third accepted; pops return words in order with correct instr_pc.
- Misalign: pc_in=32'h00400002 → no mem_req, instr_valid next cycle, instr_misalign=1, instr_out=0, instr_pc=32'h00400002.
- Flush in flight: accept 0x00400010, flush next cycle without ack → DROP, mem_req held; ack 3 cycles later with 0xDEADBEEF → discarded, instr_valid stays 0; then fetch 0x00400020 returns normally.
- Flush with simultaneous ack and pop on a full buffer → count 0, ack data discarded, state IDLE, pc_ready=1 next cycle.
